// File: rtl/fetch_pc_sequencer_pkg.sv
// fetch_pkg: shared types and constants for the fetch PC sequencer.
//   state_t     - sequencer FSM state (IDLE/RUN/HALT); encoding 2'b11 unused
//   STATE_W     - width of the state encoding as seen on state_o
//   DEFAULT_INC - default PC increment per accepted fetch
package fetch_pkg;

   localparam int unsigned STATE_W     = 2;
   localparam int unsigned DEFAULT_INC = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

endpackage

// File: rtl/fetch_pc_sequencer_pc_incrementer.sv
// pc_incrementer: combinational N-bit unsigned adder computing pc + INC.
//   pc    - current program counter (N bits)
//   sum   - (pc + INC) mod 2^N
//   carry - carry-out of the add (sum wrapped past 2^N)
module pc_incrementer #(
   parameter int unsigned N   = 32,
   parameter int unsigned INC = 4
) (
   input  logic [N-1:0] pc,
   output logic [N-1:0] sum,
   output logic         carry
);

   always_comb begin
      {carry, sum} = {1'b0, pc} + (N+1)'(INC);
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: program-counter sequencer for the fetch stage.
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   en_i              - leave IDLE and start fetching
//   halt_i            - move from RUN to HALT
//   redirect_valid_i  - load redirect_pc_i as the next PC (any state);
//                       also resumes RUN from HALT
//   redirect_pc_i     - redirect target
//   pc_ready_i        - downstream accepts the current PC
//   pc_o, pc_valid_o  - current PC and its fetch-request valid
//   wrap_o            - one-cycle pulse: last increment carried out of N bits
//   fetch_count_o     - accepted-fetch count, wraps mod 2^CW
//   state_o           - current FSM state encoding
module fetch_pc_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned   N        = 32,
   parameter int unsigned   INC      = DEFAULT_INC,
   parameter logic [N-1:0]  RESET_PC = '0,
   parameter int unsigned   CW       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_i,
   input  logic                halt_i,
   input  logic                redirect_valid_i,
   input  logic [N-1:0]        redirect_pc_i,
   input  logic                pc_ready_i,
   output logic [N-1:0]        pc_o,
   output logic                pc_valid_o,
   output logic                wrap_o,
   output logic [CW-1:0]       fetch_count_o,
   output logic [STATE_W-1:0]  state_o
);

   state_t        state;
   state_t        state_next;
   logic          valid;
   logic          handshake;
   logic [N-1:0]  pc_sum;
   logic          pc_carry;

   pc_incrementer #(
      .N   (N),
      .INC (INC)
   ) u_pc_incrementer (
      .pc    (pc_o),
      .sum   (pc_sum),
      .carry (pc_carry)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; halt outranks staying in RUN, redirect resumes HALT
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (en_i)             state_next = RUN;
         RUN:     if (halt_i)           state_next = HALT;
         HALT:    if (redirect_valid_i) state_next = RUN;
         default:                       state_next = IDLE;
      endcase
   end

   // Outputs decoded from the state register only, so they stay registered
   always_comb begin
      valid   = (state == RUN);
      state_o = state;
   end

   assign pc_valid_o = valid;
   assign handshake  = valid & pc_ready_i;

   // Redirect wins over increment, but an accepted PC is still counted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_o          <= RESET_PC;
         fetch_count_o <= '0;
         wrap_o        <= 1'b0;
      end else begin
         if (redirect_valid_i) begin
            pc_o <= redirect_pc_i;
         end else if (handshake) begin
            pc_o <= pc_sum;
         end
         if (handshake) begin
            fetch_count_o <= fetch_count_o + CW'(1);
         end
         wrap_o <= handshake & ~redirect_valid_i & pc_carry;
      end
   end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer (N=8, INC=4, RESET_PC=0, CW=16).
module tb_fetch_pc_sequencer;

   localparam int unsigned N   = 8;
   localparam int unsigned INC = 4;
   localparam int unsigned CW  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en_i = 1'b0;
   logic          halt_i = 1'b0;
   logic          redirect_valid_i = 1'b0;
   logic [N-1:0]  redirect_pc_i = '0;
   logic          pc_ready_i = 1'b0;
   logic [N-1:0]  pc_o;
   logic          pc_valid_o;
   logic          wrap_o;
   logic [CW-1:0] fetch_count_o;
   logic [1:0]    state_o;

   fetch_pc_sequencer #(
      .N        (N),
      .INC      (INC),
      .RESET_PC (8'h00),
      .CW       (CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .en_i             (en_i),
      .halt_i           (halt_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .pc_ready_i       (pc_ready_i),
      .pc_o             (pc_o),
      .pc_valid_o       (pc_valid_o),
      .wrap_o           (wrap_o),
      .fetch_count_o    (fetch_count_o),
      .state_o          (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pc;
      logic        valid;
      logic        wrap;
      logic [15:0] cnt;
      logic [1:0]  st;
   } exp_t;

   exp_t q[$];

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   // Reference model state
   logic [7:0]  m_pc;
   logic [1:0]  m_st;
   logic [15:0] m_cnt;
   logic        m_wrap;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_model();
      exp_t e;
      e.pc    = m_pc;
      e.valid = (m_st == 2'b01);
      e.wrap  = m_wrap;
      e.cnt   = m_cnt;
      e.st    = m_st;
      q.push_back(e);
   endtask

   task automatic pop_compare(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         check({tag, " queue"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         check({tag, " pc"},    32'(pc_o),          32'(e.pc));
         check({tag, " valid"}, 32'(pc_valid_o),    32'(e.valid));
         check({tag, " wrap"},  32'(wrap_o),        32'(e.wrap));
         check({tag, " count"}, 32'(fetch_count_o), 32'(e.cnt));
         check({tag, " state"}, 32'(state_o),       32'(e.st));
      end
   endtask

   task automatic model_reset();
      m_pc = 8'h00; m_st = 2'b00; m_cnt = 16'd0; m_wrap = 1'b0;
   endtask

   // Drive one cycle of inputs at the falling edge, predict, check after the rising edge
   task automatic step(input string tag, input logic en, input logic halt,
                       input logic redir, input logic [7:0] rpc, input logic ready);
      logic       hs;
      logic [8:0] add;
      @(negedge clk);
      en_i = en; halt_i = halt; redirect_valid_i = redir;
      redirect_pc_i = rpc; pc_ready_i = ready;
      hs  = (m_st == 2'b01) && ready;
      add = {1'b0, m_pc} + 9'd4;
      m_wrap = hs && !redir && add[8];
      if (hs) m_cnt = m_cnt + 16'd1;
      if (redir)   m_pc = rpc;
      else if (hs) m_pc = add[7:0];
      case (m_st)
         2'b00:   if (en)    m_st = 2'b01;
         2'b01:   if (halt)  m_st = 2'b10;
         2'b10:   if (redir) m_st = 2'b01;
         default: m_st = 2'b00;
      endcase
      push_model();
      @(posedge clk);
      #1;
      pop_compare(tag);
   endtask

   initial begin
      // Reset state
      model_reset();
      #2;
      push_model();
      pop_compare("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Start and stream: issued PCs 0,4 then stall at 8, then 8,12
      step("start",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step("hs0",    1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step("hs1",    1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("at8", 32'(pc_o), 32'h08);
      for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      check("stall valid", 32'(pc_valid_o), 32'd1);
      step("hs2",    1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step("hs3",    1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("count4", 32'(fetch_count_o), 32'd4);
      check("pc10",   32'(pc_o),          32'h10);

      // Redirect with simultaneous handshake
      step("redir40", 1'b0, 1'b0, 1'b1, 8'h40, 1'b1);
      check("redir pc",    32'(pc_o),          32'h40);
      check("redir count", 32'(fetch_count_o), 32'd5);

      // Wrap at 0xFC
      step("toFC",  1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
      step("wrap",  1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("wrap pulse", 32'(wrap_o), 32'd1);
      check("wrap pc",    32'(pc_o),   32'h00);
      step("wrap1", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("wrap clear", 32'(wrap_o), 32'd0);
      // Redirect at 0xFC with handshake: no wrap
      step("toFC2", 1'b0, 1'b0, 1'b1, 8'hFC, 1'b0);
      step("redirFC", 1'b0, 1'b0, 1'b1, 8'h50, 1'b1);

      // Halt with handshake, en ignored, redirect resumes
      step("halt",    1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      check("halt state", 32'(state_o), 32'd2);
      step("halt_en", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step("resume",  1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
      check("resume pc", 32'(pc_o), 32'h80);
      step("hs80",    1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

      // Halt and redirect together in RUN
      step("halt_redir", 1'b0, 1'b1, 1'b1, 8'h90, 1'b1);
      step("resume2",    1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
      check("at20", 32'(pc_o), 32'h20);

      // Asynchronous reset mid-RUN
      @(negedge clk);
      pc_ready_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      push_model();
      pop_compare("async_rst");
      @(posedge clk);
      #1;
      push_model();
      pop_compare("held_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Redirect in IDLE loads PC but stays IDLE; en then starts
      step("idle_redir", 1'b0, 1'b0, 1'b1, 8'h30, 1'b1);
      step("idle_wait",  1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      step("restart",    1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step("hs30",       1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      check("pc34", 32'(pc_o), 32'h34);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Parametrised program-counter sequencer for the fetch stage, successor to the combinational fetch adder. It holds the current PC, advances it by a configurable increment on each accepted fetch, and supports redirect (branch/jump target load), halt/resume and downstream back-pressure via a valid/ready handshake. It sits between the control unit (redirect, halt, enable) and the instruction-memory request port (PC output).

## Interface
Parameters:
- N, 32, PC width in bits
- INC, 4, increment added per accepted fetch (1 ≤ INC < 2^N)
- RESET_PC, 0, PC value loaded on reset
- CW, 16, width of the fetch counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- en_i  input  1  start fetching from IDLE
- halt_i  input  1  request transition to HALT
- redirect_valid_i  input  1  load redirect_pc_i as next PC
- redirect_pc_i  input  N  redirect target
- pc_ready_i  input  1  downstream accepts current PC
- pc_o  output  N  current PC
- pc_valid_o  output  1  pc_o is a valid fetch request
- wrap_o  output  1  one-cycle pulse: last increment overflowed 2^N
- fetch_count_o  output  CW  number of accepted fetches, wraps mod 2^CW
- state_o  output  2  current FSM state encoding

## Operation
- FSM states: IDLE (00), RUN (01), HALT (10); 11 unused, decodes to IDLE.
- IDLE: pc_valid_o=0; en_i=1 -> RUN next cycle. PC unchanged.
- RUN: pc_valid_o=1. Handshake = pc_valid_o & pc_ready_i. On handshake with no redirect: pc <= (pc + INC) mod 2^N, fetch_count += 1, wrap_o <= carry-out of the add.
- pc_ready_i=0 in RUN: pc_o, fetch_count_o held (stall); pc_valid_o stays 1 — must not drop while waiting.
- halt_i=1 in RUN -> HALT next cycle; a handshake in the same cycle still counts and advances the PC.
- HALT: pc_valid_o=0; PC held. redirect_valid_i=1 -> RUN next cycle with pc = redirect_pc_i. en_i alone does not resume.
- Redirect (any state): pc <= redirect_pc_i; overrides increment even if handshake occurs the same cycle; the handshake is still counted (the accepted PC was issued). wrap_o=0 on redirect cycles.
- Redirect in IDLE loads PC but stays IDLE unless en_i=1.
- halt_i and redirect_valid_i together in RUN: PC loads target, state -> HALT.
- Priority: reset > redirect (PC) ; halt > stay (state).
- Arithmetic: N-bit unsigned add, INC zero-extended; carry-out only drives wrap_o.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Reset values: pc_o=RESET_PC, pc_valid_o=0, wrap_o=0, fetch_count_o=0, state_o=IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); first RUN cycle requires en_i after rst_n deasserts.
- Latency: handshake at edge k -> new pc_o visible after edge k (1 cycle). Redirect same. State change 1 cycle.
- Back-to-back: pc_ready_i held 1 in RUN -> one new PC per cycle, full throughput.

## Structure
- Package fetch_pkg: state enum (IDLE, RUN, HALT), default INC constant, state encoding width.
- Sub-module pc_incrementer: combinational N-bit adder, pc + INC, returning sum and carry-out; instantiated once.
- Top: FSM, PC register, counter, wrap register.

## Test plan
- Reset then en_i=1, pc_ready_i=1 for 4 cycles (N=8, INC=4, RESET_PC=0) -> pc_o 0,4,8,12; fetch_count_o=4.
- pc_ready_i=0 for 3 cycles at pc_o=8 -> pc_o stays 8, pc_valid_o stays 1, count unchanged.
- N=8, pc_o=0xFC, handshake -> pc_o=0x00, wrap_o=1 for exactly one cycle.
- Redirect to 0x40 with simultaneous handshake at pc_o=0x10 -> pc_o=0x40, count +1, wrap_o=0.
- halt_i in RUN -> HALT, pc_valid_o=0; en_i=1 ignored; redirect 0x80 -> RUN, pc_o=0x80.
- rst_n low mid-RUN at pc_o=0x20 -> immediately pc_o=RESET_PC, valid 0, state IDLE, count 0.
